// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier: one add/subtract-and-shift step per clock,
// WIDTH steps per operation, 2*WIDTH-bit product with a one-cycle done pulse.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic                 do_add;
  logic                 do_sub;
  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       acc_sum;
  logic [WIDTH:0]       acc_sh;
  logic [WIDTH-1:0]     q_sh;
  logic                 q1_sh;

  // M is sign-extended to WIDTH+1 bits before negation so -(-2^(WIDTH-1)) stays exact.
  always_comb begin
    do_add  = (q_q[0] == 1'b0) && (q1_q == 1'b1);
    do_sub  = (q_q[0] == 1'b1) && (q1_q == 1'b0);
    m_ext   = {m_q[WIDTH-1], m_q};
    addend  = (m_ext ^ {(WIDTH+1){do_sub}}) + {{WIDTH{1'b0}}, do_sub};
    acc_sum = (do_add || do_sub) ? (acc_q + addend) : acc_q;
    {acc_sh, q_sh, q1_sh} = {acc_sum[WIDTH], acc_sum, q_q};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          q1_d    = 1'b0;
          acc_d   = '0;
          count_d = COUNT_INIT;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_sh;
        q_d     = q_sh;
        q1_d    = q1_sh;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = {acc_sh[WIDTH-1:0], q_sh};
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule
